// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the cache/main-memory block arbiter.
// Optional round-robin arbitration is enabled with the MEM_ARB_RR_EN macro.
package mem_arb_pkg;

    localparam int BLOCK_W = 128;
    localparam int BADDR_W = 28;

    typedef enum logic [2:0] {
        IDLE,
        GRANT_I,
        GRANT_D,
        RESP_I,
        RESP_D
    } arb_state_t;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/mem_arb_select.sv
// Combinational winner pick between the instruction and data requesters.
// MEM_ARB_RR_EN selects round-robin on ties; otherwise data always wins.
module mem_arb_select
    import mem_arb_pkg::*;
(
    input  logic i_req_i,
    input  logic i_req_d,
`ifdef MEM_ARB_RR_EN
    input  logic i_last_grant,
`endif
    output logic o_grant_valid,
    output logic o_grant_port
);

    always_comb begin
        o_grant_valid = i_req_i | i_req_d;
        o_grant_port  = PORT_I;
        if (i_req_i && i_req_d) begin
`ifdef MEM_ARB_RR_EN
            o_grant_port = (i_last_grant == PORT_I) ? PORT_D : PORT_I;
`else
            o_grant_port = PORT_D;
`endif
        end else if (i_req_d) begin
            o_grant_port = PORT_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one main-memory block port between the I-cache and D-cache.
// Build with MEM_ARB_RR_EN for round-robin tie-breaking (default: data first).
module mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic               CLK,
    input  logic               RESET,
    input  logic               inst_read,
    input  logic [BADDR_W-1:0] inst_address,
    output logic [BLOCK_W-1:0] inst_readdata,
    output logic               inst_busywait,
    input  logic               data_read,
    input  logic               data_write,
    input  logic [BADDR_W-1:0] data_address,
    input  logic [BLOCK_W-1:0] data_writedata,
    output logic [BLOCK_W-1:0] data_readdata,
    output logic               data_busywait,
    output logic               mem_read,
    output logic               mem_write,
    output logic [BADDR_W-1:0] mem_address,
    output logic [BLOCK_W-1:0] mem_writedata,
    input  logic [BLOCK_W-1:0] mem_readdata,
    input  logic               mem_busywait
);

    arb_state_t         r_state;
    arb_state_t         w_next;
    logic               r_mem_read;
    logic               r_mem_write;
    logic [BADDR_W-1:0] r_mem_address;
    logic [BLOCK_W-1:0] r_mem_writedata;
    logic [BLOCK_W-1:0] r_inst_readdata;
    logic [BLOCK_W-1:0] r_data_readdata;
    logic               r_seen_busy;
    logic               w_req_d;
    logic               w_grant_valid;
    logic               w_grant_port;
    logic               w_done;

    assign w_req_d = data_read | data_write;
    // Memory may still show idle in the strobe cycle; only a busy-to-idle edge completes.
    assign w_done  = r_seen_busy & ~mem_busywait;

`ifdef MEM_ARB_RR_EN
    logic r_last_grant;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_last_grant <= PORT_I;
        end else if (r_state == IDLE && w_grant_valid) begin
            r_last_grant <= w_grant_port;
        end
    end

    mem_arb_select u_select (
        .i_req_i       (inst_read),
        .i_req_d       (w_req_d),
        .i_last_grant  (r_last_grant),
        .o_grant_valid (w_grant_valid),
        .o_grant_port  (w_grant_port)
    );
`else
    mem_arb_select u_select (
        .i_req_i       (inst_read),
        .i_req_d       (w_req_d),
        .o_grant_valid (w_grant_valid),
        .o_grant_port  (w_grant_port)
    );
`endif

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant_valid) begin
                    w_next = (w_grant_port == PORT_D) ? GRANT_D : GRANT_I;
                end
            end
            GRANT_I: if (w_done) w_next = RESP_I;
            GRANT_D: if (w_done) w_next = RESP_D;
            RESP_I:  w_next = IDLE;
            RESP_D:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_mem_read      <= 1'b0;
            r_mem_write     <= 1'b0;
            r_mem_address   <= '0;
            r_mem_writedata <= '0;
            r_inst_readdata <= '0;
            r_data_readdata <= '0;
            r_seen_busy     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_valid) begin
                        if (w_grant_port == PORT_D) begin
                            r_mem_address   <= data_address;
                            r_mem_writedata <= data_writedata;
                            r_mem_write     <= data_write;
                            r_mem_read      <= ~data_write;
                        end else begin
                            r_mem_address <= inst_address;
                            r_mem_write   <= 1'b0;
                            r_mem_read    <= 1'b1;
                        end
                    end
                end
                GRANT_I, GRANT_D: begin
                    if (mem_busywait) begin
                        r_seen_busy <= 1'b1;
                    end
                    if (w_done) begin
                        if (r_mem_read) begin
                            if (r_state == GRANT_I) begin
                                r_inst_readdata <= mem_readdata;
                            end else begin
                                r_data_readdata <= mem_readdata;
                            end
                        end
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        r_seen_busy <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_read      = r_mem_read;
    assign mem_write     = r_mem_write;
    assign mem_address   = r_mem_address;
    assign mem_writedata = r_mem_writedata;
    assign inst_readdata = r_inst_readdata;
    assign data_readdata = r_data_readdata;
    assign inst_busywait = inst_read & (r_state != RESP_I);
    assign data_busywait = w_req_d & (r_state != RESP_D);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a 4-cycle-busy memory model.
// Tie-break expectations follow MEM_ARB_RR_EN when the bench is built with it.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int MEM_LAT = 4;
    localparam int TMO     = 40;

    logic               CLK = 1'b0;
    logic               RESET;
    logic               inst_read;
    logic [BADDR_W-1:0] inst_address;
    logic [BLOCK_W-1:0] inst_readdata;
    logic               inst_busywait;
    logic               data_read;
    logic               data_write;
    logic [BADDR_W-1:0] data_address;
    logic [BLOCK_W-1:0] data_writedata;
    logic [BLOCK_W-1:0] data_readdata;
    logic               data_busywait;
    logic               mem_read;
    logic               mem_write;
    logic [BADDR_W-1:0] mem_address;
    logic [BLOCK_W-1:0] mem_writedata;
    logic [BLOCK_W-1:0] mem_readdata;
    logic               mem_busywait;

    always #5 CLK = ~CLK;

    mem_arbiter dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .inst_read      (inst_read),
        .inst_address   (inst_address),
        .inst_readdata  (inst_readdata),
        .inst_busywait  (inst_busywait),
        .data_read      (data_read),
        .data_write     (data_write),
        .data_address   (data_address),
        .data_writedata (data_writedata),
        .data_readdata  (data_readdata),
        .data_busywait  (data_busywait),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_writedata  (mem_writedata),
        .mem_readdata   (mem_readdata),
        .mem_busywait   (mem_busywait)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [127:0] mdata(input logic [27:0] a);
        return {{3{32'hDEADBEEF}}, 4'h0, a};
    endfunction

    // Memory model: busy rises one edge after the strobe, stays high MEM_LAT cycles.
    logic m_active, m_done;
    int   m_cnt;
    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            mem_busywait <= 1'b0;
            m_active     <= 1'b0;
            m_done       <= 1'b0;
            m_cnt        <= 0;
            mem_readdata <= '0;
        end else if (m_active) begin
            if (m_cnt > 1) begin
                m_cnt <= m_cnt - 1;
            end else begin
                mem_busywait <= 1'b0;
                m_active     <= 1'b0;
                m_done       <= 1'b1;
                mem_readdata <= mdata(mem_address);
            end
        end else if (mem_read || mem_write) begin
            if (!m_done) begin
                m_active     <= 1'b1;
                m_cnt        <= MEM_LAT;
                mem_busywait <= 1'b1;
                mem_readdata <= {4{32'hBAD0BAD0}};
            end
        end else begin
            m_done <= 1'b0;
        end
    end

    typedef struct {
        logic        rd;
        logic        wr;
        logic [27:0] addr;
        logic [127:0] wd;
    } op_t;

    op_t  q_exp[$];
    logic mon_prev = 1'b0;

    always @(negedge CLK) begin
        op_t e;
        if (RESET && (mem_read || mem_write) && !mon_prev) begin
            if (q_exp.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL memop_unexpected actual rd=%b wr=%b addr=%h required none",
                         mem_read, mem_write, mem_address);
            end else begin
                e = q_exp.pop_front();
                check("memop_dir", {126'h0, mem_read, mem_write}, {126'h0, e.rd, e.wr});
                check("memop_addr", {100'h0, mem_address}, {100'h0, e.addr});
                if (e.wr) check("memop_wdata", mem_writedata, e.wd);
            end
        end
        mon_prev = RESET && (mem_read || mem_write);
    end

    typedef struct {
        logic         is_d;
        logic         rd;
        logic         wr;
        logic [27:0]  addr;
        logic [127:0] wdata;
        logic         exp_rd;
        logic         exp_wr;
        int           exp_cyc;
    } vec_t;

    vec_t         vecs[6];
    logic [127:0] exp_i_rd = '0;
    logic [127:0] exp_d_rd = '0;
    logic         tb_last  = PORT_I;

    task automatic wait_low(input logic is_d, output int cyc, output logic other_hi);
        logic bw;
        cyc      = 0;
        bw       = 1'b1;
        other_hi = 1'b1;
        while (bw && cyc < TMO) begin
            @(negedge CLK);
            cyc++;
            bw = is_d ? data_busywait : inst_busywait;
            if (bw && !(is_d ? inst_busywait | !inst_read : data_busywait | !(data_read | data_write)))
                other_hi = 1'b0;
        end
    endtask

    task automatic do_txn(input vec_t v);
        int           cyc;
        logic         bw;
        logic         oh;
        logic [127:0] old_rd;
        @(negedge CLK);
        if (v.is_d) begin
            data_read      = v.rd;
            data_write     = v.wr;
            data_address   = v.addr;
            data_writedata = v.wdata;
        end else begin
            inst_read    = 1'b1;
            inst_address = v.addr;
        end
        q_exp.push_back('{v.exp_rd, v.exp_wr, v.addr, v.wdata});
        old_rd = v.is_d ? exp_d_rd : exp_i_rd;
        cyc = 0;
        bw  = 1'b1;
        oh  = 1'b1;
        while (bw && cyc < TMO) begin
            @(negedge CLK);
            cyc++;
            bw = v.is_d ? data_busywait : inst_busywait;
            if (cyc == 2) check("early_rd", v.is_d ? data_readdata : inst_readdata, old_rd);
        end
        check("latency", 128'(cyc), 128'(v.exp_cyc));
        if (v.exp_rd) begin
            if (v.is_d) exp_d_rd = mdata(v.addr);
            else        exp_i_rd = mdata(v.addr);
        end
        check("i_rdata", inst_readdata, exp_i_rd);
        check("d_rdata", data_readdata, exp_d_rd);
        @(negedge CLK);
        check("bw_one_cycle", {127'h0, v.is_d ? data_busywait : inst_busywait}, 128'h1);
        inst_read  = 1'b0;
        data_read  = 1'b0;
        data_write = 1'b0;
        tb_last    = v.is_d ? PORT_D : PORT_I;
    endtask

    task automatic do_pair(input logic [27:0] ai, input logic [27:0] ad);
        logic first_d;
        int   cyc;
        logic other_hi;
`ifdef MEM_ARB_RR_EN
        first_d = (tb_last == PORT_I);
`else
        first_d = 1'b1;
`endif
        @(negedge CLK);
        inst_read    = 1'b1;
        inst_address = ai;
        data_read    = 1'b1;
        data_write   = 1'b0;
        data_address = ad;
        if (first_d) begin
            q_exp.push_back('{1'b1, 1'b0, ad, 128'h0});
            q_exp.push_back('{1'b1, 1'b0, ai, 128'h0});
        end else begin
            q_exp.push_back('{1'b1, 1'b0, ai, 128'h0});
            q_exp.push_back('{1'b1, 1'b0, ad, 128'h0});
        end
        wait_low(first_d, cyc, other_hi);
        check("pair_first_lat", 128'(cyc), 128'd7);
        check("pair_loser_stall", {127'h0, other_hi}, 128'h1);
        if (first_d) begin
            exp_d_rd  = mdata(ad);
            data_read = 1'b0;
        end else begin
            exp_i_rd  = mdata(ai);
            inst_read = 1'b0;
        end
        wait_low(!first_d, cyc, other_hi);
        check("pair_second_to", {127'h0, cyc < TMO}, 128'h1);
        if (first_d) exp_i_rd = mdata(ai);
        else         exp_d_rd = mdata(ad);
        check("pair_i_rdata", inst_readdata, exp_i_rd);
        check("pair_d_rdata", data_readdata, exp_d_rd);
        inst_read = 1'b0;
        data_read = 1'b0;
        tb_last   = first_d ? PORT_I : PORT_D;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cyc;
        logic oh;

        vecs[0] = '{1'b0, 1'b1, 1'b0, 28'h0000010, 128'h0,         1'b1, 1'b0, 7};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 28'h0000020, {16{8'hA5}},    1'b0, 1'b1, 7};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 28'h0000030, 128'h0,         1'b1, 1'b0, 7};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 28'hFFFFFFF, 128'h0,         1'b1, 1'b0, 7};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 28'h0000040, {16{8'h5A}},    1'b0, 1'b1, 7};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 28'h0000000, {128{1'b1}},    1'b0, 1'b1, 7};

        RESET          = 1'b0;
        inst_read      = 1'b1;
        inst_address   = '0;
        data_read      = 1'b0;
        data_write     = 1'b0;
        data_address   = '0;
        data_writedata = '0;
        #12;
        check("rst_mem_read", {127'h0, mem_read}, 128'h0);
        check("rst_mem_write", {127'h0, mem_write}, 128'h0);
        check("rst_mem_addr", {100'h0, mem_address}, 128'h0);
        check("rst_mem_wdata", mem_writedata, 128'h0);
        check("rst_i_rdata", inst_readdata, 128'h0);
        check("rst_d_rdata", data_readdata, 128'h0);
        check("rst_i_bw_follow", {127'h0, inst_busywait}, 128'h1);
        inst_read = 1'b0;
        #1;
        check("rst_i_bw_idle", {127'h0, inst_busywait}, 128'h0);
        @(negedge CLK);
        #2 RESET = 1'b1;

        for (int i = 0; i < 6; i++) do_txn(vecs[i]);

        do_pair(28'h0000100, 28'h0000200);
        do_pair(28'h0000101, 28'h0000201);
        do_pair(28'h0000102, 28'h0000202);

        // Reset in the middle of a data write, then re-grant after release.
        @(negedge CLK);
        data_write     = 1'b1;
        data_address   = 28'h0000050;
        data_writedata = {16{8'h3C}};
        q_exp.push_back('{1'b0, 1'b1, 28'h0000050, {16{8'h3C}}});
        repeat (3) @(negedge CLK);
        check("pre_rst_write", {127'h0, mem_write}, 128'h1);
        #2 RESET = 1'b0;
        #1;
        check("midrst_mem_write", {127'h0, mem_write}, 128'h0);
        check("midrst_mem_addr", {100'h0, mem_address}, 128'h0);
        check("midrst_d_bw", {127'h0, data_busywait}, 128'h1);
        exp_i_rd = '0;
        exp_d_rd = '0;
        tb_last  = PORT_I;
        check("midrst_d_rdata", data_readdata, exp_d_rd);
        @(negedge CLK);
        #2 RESET = 1'b1;
        q_exp.push_back('{1'b0, 1'b1, 28'h0000050, {16{8'h3C}}});
        @(posedge CLK);
        #1;
        check("regrant_write", {127'h0, mem_write}, 128'h1);
        wait_low(1'b1, cyc, oh);
        check("regrant_done", {127'h0, cyc < TMO}, 128'h1);
        data_write = 1'b0;
        tb_last    = PORT_D;
        repeat (2) @(negedge CLK);
        check("queue_drained", 128'(q_exp.size()), 128'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
